struct_channel_sender: RTL and testbench
========================================

# struct_channel_sender

Transmit-side endpoint for the two-bit struct channel (fields `a`, `b`) whose consumer sees only an input modport on `_b`. Local logic pushes struct words into a DEPTH-entry FIFO. The block presents the head entry on the channel with a valid/ready handshake. It keeps `_b` stable whenever the channel is idle, so a consumer that only samples `_b` never sees glitches.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..64.
- CW, $clog2(DEPTH)+1, width of the occupancy count; derived, not overridable.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_push  input  1  write request from the local producer.
- i_a  input  1  struct field `a` of the pushed word.
- i_b  input  1  struct field `b` of the pushed word.
- o_full  output  1  FIFO holds DEPTH entries.
- o_count  output  CW  current occupancy, 0..DEPTH.
- o_drop  output  8  saturating count of pushes rejected because the FIFO was full.
- o_valid  output  1  channel word valid.
- i_ready  input  1  consumer accepts the word.
- o_ch_a  output  1  channel field `a` (drives `_b.a`).
- o_ch_b  output  1  channel field `b` (drives `_b.b`).

## Operation
- Storage: DEPTH×2-bit array, write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in a separate CW-bit counter.
- Push is accepted when `i_push && (!o_full || pop)`. An accepted push writes {i_a, i_b} at `wp` and increments `wp`.
- Push is rejected when `i_push && o_full && !pop`. A rejected push leaves the FIFO unchanged and increments `o_drop`, which saturates at 255.
- Pop = `o_valid && i_ready`. Pop increments `rp`.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Output register stage holds the channel word. States:
  - IDLE: o_valid=0. o_ch_a/o_ch_b hold the last transferred word, or 0 after reset.
  - SEND: o_valid=1. o_ch_a/o_ch_b equal the FIFO head.
- Transitions:
  - IDLE→SEND when count>0. The head word is loaded into the output register on the same edge.
  - SEND→SEND on pop when count>1; the next head is loaded.
  - SEND→IDLE on pop when count==1 and there is no same-cycle push.
  - SEND holds without change while `!i_ready`.
- Handshake rules:
  - o_valid never deasserts and o_ch_* never change while o_valid=1 && !i_ready.
  - i_ready may be high while o_valid=0; it has no effect then.
- The output register is part of the FIFO, not extra capacity: an entry remains counted until it is popped.
- o_full = (count==DEPTH). o_full is combinational from the counter.

## Timing
- Reset (asynchronous assert, release synchronous to i_clk) sets:
  - wp=rp=0, count=0, o_full=0, o_drop=0;
  - o_valid=0, o_ch_a=0, o_ch_b=0;
  - state IDLE.
- Reset mid-transfer discards all entries. No word is presented after release until a new push.
- Latency: a push into an empty FIFO at edge N gives o_valid=1 with that word after edge N+1.
- Throughput: one word per cycle while i_ready=1 and the FIFO is non-empty.
- Full with simultaneous push and pop: both are accepted, count stays DEPTH, and nothing is dropped.
- Empty with simultaneous push and pop is impossible, because pop requires o_valid, which requires count>0.
- Pointer wrap: after DEPTH pushes, wp=0. Ordering stays FIFO across the wrap.
- The last pop coinciding with a push stays in SEND and loads the newly pushed word on the next edge. A one-cycle valid bubble is permitted only in this case.

## Test plan
- Reset then idle: o_valid=0, o_ch=00, o_count=0, o_drop=0. Assert i_rst mid-stream with 3 entries queued: o_valid=0 and o_count=0 immediately; no stale word appears after release.
- Push 01,10,11 with i_ready=1: the channel presents 01,10,11 on consecutive cycles, the first one cycle after its push. o_ch holds 11 after o_valid falls.
- i_ready=0, push 6 words (DEPTH=4): o_full=1 after the 4th push, o_drop=2, o_count=4. Then i_ready=1: exactly the first 4 words emerge, in order.
- Backpressure stability: toggle i_ready randomly. o_ch never changes while o_valid=1 && i_ready=0.
- FIFO full and i_ready=1, push every cycle for 20 cycles: o_drop stays 0, o_count stays 4, and the output order matches the input order across pointer wrap.
- Overflow saturation: hold FIFO full with i_ready=0 and push 300 times: o_drop=255.

Source files
------------

// File: rtl/struct_channel_sender_if.sv
// rtl/struct_channel_sender_if.sv - two-bit struct channel (a, b) with valid/ready handshake
interface struct_channel_sender_if;
  logic o_valid;
  logic i_ready;
  logic o_ch_a;
  logic o_ch_b;

  modport master (output o_valid, output o_ch_a, output o_ch_b, input i_ready);
  modport slave  (input o_valid, input o_ch_a, input o_ch_b, output i_ready);
endinterface

// File: rtl/struct_channel_sender.sv
// rtl/struct_channel_sender.sv - FIFO-backed transmit endpoint for the struct channel
// The output register presents the FIFO head; the word stays counted until it is popped.
module struct_channel_sender #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_a,
  input  logic                   i_b,
  output logic                   o_full,
  output logic [CW-1:0]          o_count,
  output logic [7:0]             o_drop,
  struct_channel_sender_if.master ch
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_n;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wp, rp, rp_inc;
  logic [CW-1:0]   count;
  logic [7:0]      drop;
  logic [1:0]      word, load_word;
  logic            load, valid, pop, push_ok, push_rej;

  assign valid    = (state == SEND);
  assign pop      = valid && ch.i_ready;
  assign o_full   = (count == CW'(DEPTH));
  assign push_ok  = i_push && (!o_full || pop);
  assign push_rej = i_push && o_full && !pop;
  assign rp_inc   = rp + AW'(1);

  assign o_count   = count;
  assign o_drop    = drop;
  assign ch.o_valid = valid;
  assign ch.o_ch_a  = word[1];
  assign ch.o_ch_b  = word[0];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wp] <= {i_a, i_b};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      drop  <= '0;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop)     rp <= rp_inc;
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_rej && drop != 8'hFF) drop <= drop + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      word  <= 2'b00;
    end else begin
      state <= state_n;
      if (load) word <= load_word;
    end
  end

  // A last pop that coincides with a push forwards the pushed word directly, avoiding a bubble.
  always_comb begin
    state_n   = state;
    load      = 1'b0;
    load_word = mem[rp];
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_n   = SEND;
          load      = 1'b1;
          load_word = mem[rp];
        end
      end
      SEND: begin
        if (pop) begin
          if (count > CW'(1)) begin
            load      = 1'b1;
            load_word = mem[rp_inc];
          end else if (push_ok) begin
            load      = 1'b1;
            load_word = {i_a, i_b};
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_struct_channel_sender.sv
// tb/tb_struct_channel_sender.sv - self-checking bench for struct_channel_sender
module tb_struct_channel_sender;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          full;
  logic [CW-1:0] count;
  logic [7:0]    drop;

  struct_channel_sender_if ch();

  struct_channel_sender #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_push(push), .i_a(a), .i_b(b),
    .o_full(full), .o_count(count), .o_drop(drop), .ch(ch.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words, the presented word is always the queue head.
  logic [1:0] m_q[$];
  bit         m_valid;
  logic [1:0] m_ch;
  int         m_drop;
  int         m_pre;
  bit         m_pop, m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_valid = 0;
      m_ch    = 2'b00;
      m_drop  = 0;
    end else begin
      m_pre = m_q.size();
      m_pop = m_valid && ch.i_ready;
      m_acc = push && (m_pre < DEPTH || m_pop);
      if (m_pop) void'(m_q.pop_front());
      if (m_acc) m_q.push_back({a, b});
      else if (push && m_drop < 255) m_drop++;
      if (m_valid) begin
        if (m_pop) begin
          if (m_q.size() > 0) m_ch = m_q[0];
          else m_valid = 0;
        end
      end else if (m_pre > 0) begin
        m_valid = 1;
        m_ch    = m_q[0];
      end
    end
  end

  bit         hold_prev = 0;
  logic [1:0] ch_prev = 2'b00;

  always @(negedge clk) begin
    if (!rst) begin
      check("model_valid", int'(ch.o_valid), int'(m_valid));
      check("model_ch",    int'({ch.o_ch_a, ch.o_ch_b}), int'(m_ch));
      check("model_count", int'(count), m_q.size());
      check("model_full",  int'(full), int'(m_q.size() == DEPTH));
      check("model_drop",  int'(drop), m_drop);
      if (hold_prev) begin
        check("hold_valid", int'(ch.o_valid), 1);
        check("hold_ch",    int'({ch.o_ch_a, ch.o_ch_b}), int'(ch_prev));
      end
      hold_prev = ch.o_valid && !ch.i_ready;
      ch_prev   = {ch.o_ch_a, ch.o_ch_b};
    end else begin
      hold_prev = 0;
    end
  end

  task automatic step(input bit p, input logic [1:0] w, input bit r);
    push = p;
    {a, b} = w;
    ch.i_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 0;
    ch.i_ready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  logic [1:0] w6 [6];

  initial begin
    ch.i_ready = 1'b0;
    w6[0] = 2'b01; w6[1] = 2'b10; w6[2] = 2'b11;
    w6[3] = 2'b00; w6[4] = 2'b01; w6[5] = 2'b10;

    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_valid", int'(ch.o_valid), 0);
    check("rst_ch",    int'({ch.o_ch_a, ch.o_ch_b}), 0);
    check("rst_count", int'(count), 0);
    check("rst_drop",  int'(drop), 0);
    step(0, 2'b00, 1);
    check("idle_valid", int'(ch.o_valid), 0);

    step(1, 2'b01, 1);
    check("lat_count", int'(count), 1);
    check("lat_valid0", int'(ch.o_valid), 0);
    step(1, 2'b10, 1);
    check("seq_v1", int'(ch.o_valid), 1);
    check("seq_w1", int'({ch.o_ch_a, ch.o_ch_b}), 1);
    step(1, 2'b11, 1);
    check("seq_w2", int'({ch.o_ch_a, ch.o_ch_b}), 2);
    step(0, 2'b00, 1);
    check("seq_w3", int'({ch.o_ch_a, ch.o_ch_b}), 3);
    step(0, 2'b00, 1);
    check("seq_end_valid", int'(ch.o_valid), 0);
    check("seq_end_ch",    int'({ch.o_ch_a, ch.o_ch_b}), 3);

    for (int i = 0; i < 6; i++) begin
      step(1, w6[i], 0);
      if (i == 3) check("full_after4", int'(full), 1);
    end
    check("ovf_drop",  int'(drop), 2);
    check("ovf_count", int'(count), 4);
    check("ovf_head",  int'({ch.o_ch_a, ch.o_ch_b}), int'(w6[0]));
    for (int i = 1; i < 4; i++) begin
      step(0, 2'b00, 1);
      check("drain_w", int'({ch.o_ch_a, ch.o_ch_b}), int'(w6[i]));
      check("drain_v", int'(ch.o_valid), 1);
    end
    step(0, 2'b00, 1);
    check("drain_done", int'(ch.o_valid), 0);

    for (int i = 0; i < 3; i++) step(1, 2'(i + 1), 0);
    rst = 1;
    #1;
    check("midrst_valid", int'(ch.o_valid), 0);
    check("midrst_count", int'(count), 0);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 1);
      check("post_rst_valid", int'(ch.o_valid), 0);
    end

    for (int i = 0; i < 60; i++)
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2'(i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 2'((3 * i + 1) % 4), 1);
      check("stream_count", int'(count), 4);
      check("stream_drop",  int'(drop), 0);
    end
    check("wrap_head_valid", int'(ch.o_valid), 1);
    check("wrap_head_ch",    int'({ch.o_ch_a, ch.o_ch_b}), 1);

    do_reset();
    for (int i = 0; i < 300; i++) step(1, 2'b11, 0);
    check("sat_drop",  int'(drop), 255);
    check("sat_count", int'(count), 4);

    step(0, 2'b00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
